// File: rtl/alu_sched.sv
// alu_sched: arbitrates two requesters onto one external ALU, returns results and owns the N/Z/V flags
module alu_sched #(
  parameter int FIXED_PRIO = 0,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [3:0]    req0_op,
  input  logic [DW-1:0] req0_src0,
  input  logic [DW-1:0] req0_src1,
  input  logic [3:0]    req0_shamt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [3:0]    req1_op,
  input  logic [DW-1:0] req1_src0,
  input  logic [DW-1:0] req1_src1,
  input  logic [3:0]    req1_shamt,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp1_err,
  output logic [3:0]    alu_op,
  output logic [DW-1:0] alu_src0,
  output logic [DW-1:0] alu_src1,
  output logic [3:0]    alu_shamt,
  input  logic [DW-1:0] alu_dst,
  input  logic          alu_ov,
  input  logic          alu_zr,
  input  logic          alu_neg,
  input  logic          alu_change_v,
  input  logic          alu_change_z,
  input  logic          alu_change_n,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          halted
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, rr_q, rr_d, err_q, err_d, halted_q, halted_d;
  logic fv_q, fv_d, fz_q, fz_d, fn_q, fn_d;
  logic [3:0] op_q, op_d, sh_q, sh_d;
  logic [DW-1:0] s0_q, s0_d, s1_q, s1_d, rd_q, rd_d;
  logic pick, fire, ill;
  // rr_q holds the last granted id; on a tie the other requester wins
  assign pick = (req0_valid && req1_valid) ? ((FIXED_PRIO != 0) ? 1'b0 : ~rr_q) : req1_valid;
  assign fire = (state_q == IDLE) && (req0_valid || req1_valid) && !halted_q;
  assign ill = grant_q && op_q[3];
  assign req0_ready = fire && !pick;
  assign req1_ready = fire && pick;
  assign rsp0_valid = (state_q == RESP) && !grant_q;
  assign rsp1_valid = (state_q == RESP) && grant_q;
  assign rsp_data = rd_q;
  assign rsp1_err = err_q;
  assign alu_op = op_q;
  assign alu_src0 = s0_q;
  assign alu_src1 = s1_q;
  assign alu_shamt = sh_q;
  assign flag_v = fv_q;
  assign flag_z = fz_q;
  assign flag_n = fn_q;
  assign halted = halted_q;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    err_d = err_q;
    halted_d = halted_q;
    fv_d = fv_q;
    fz_d = fz_q;
    fn_d = fn_q;
    op_d = op_q;
    sh_d = sh_q;
    s0_d = s0_q;
    s1_d = s1_q;
    rd_d = rd_q;
    case (state_q)
      IDLE: if (fire) begin
        state_d = EXEC;
        grant_d = pick;
        rr_d = pick;
        op_d = pick ? req1_op : req0_op;
        s0_d = pick ? req1_src0 : req0_src0;
        s1_d = pick ? req1_src1 : req0_src1;
        sh_d = pick ? req1_shamt : req0_shamt;
      end
      EXEC: begin
        state_d = RESP;
        rd_d = ill ? '0 : alu_dst;
        err_d = ill;
        if (!grant_q) begin
          fv_d = alu_change_v ? alu_ov : fv_q;
          fz_d = alu_change_z ? alu_zr : fz_q;
          fn_d = alu_change_n ? alu_neg : fn_q;
          halted_d = halted_q || (op_q == 4'hF);
        end
      end
      RESP: state_d = (grant_q ? rsp1_ready : rsp0_ready) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      rr_q <= 1'b1;
      err_q <= 1'b0;
      halted_q <= 1'b0;
      fv_q <= 1'b0;
      fz_q <= 1'b0;
      fn_q <= 1'b0;
      op_q <= '0;
      sh_q <= '0;
      s0_q <= '0;
      s1_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      err_q <= err_d;
      halted_q <= halted_d;
      fv_q <= fv_d;
      fz_q <= fz_d;
      fn_q <= fn_d;
      op_q <= op_d;
      sh_q <= sh_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed bench with an ALU stand-in and a response scoreboard for alu_sched
module tb_alu_sched;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [3:0] req0_op = '0, req1_op = '0, req0_shamt = '0, req1_shamt = '0;
  logic [15:0] req0_src0 = '0, req0_src1 = '0, req1_src0 = '0, req1_src1 = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp1_err, flag_z, flag_v, flag_n, halted;
  logic [15:0] rsp_data, alu_src0, alu_src1, alu_dst;
  logic [3:0] alu_op, alu_shamt;
  logic alu_ov, alu_zr, alu_neg, alu_change_v, alu_change_z, alu_change_n;

  alu_sched #(.FIXED_PRIO(0), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src0(req0_src0), .req0_src1(req0_src1), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src0(req1_src0), .req1_src1(req1_src1), .req1_shamt(req1_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp1_err(rsp1_err),
    .alu_op(alu_op), .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_shamt(alu_shamt),
    .alu_dst(alu_dst), .alu_ov(alu_ov), .alu_zr(alu_zr), .alu_neg(alu_neg),
    .alu_change_v(alu_change_v), .alu_change_z(alu_change_z), .alu_change_n(alu_change_n),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .halted(halted)
  );

  typedef struct {int id; logic [15:0] d; logic e, v, z, n, h; int t;} exp_t;
  exp_t sb[$];
  int glog[$];
  int total = 0, bad = 0, cyc = 0;
  logic prev_v = 1'b0, mv = 1'b0, mz = 1'b0, mn = 1'b0, mh = 1'b0, last_err = 1'b0;
  logic [15:0] last_data = '0;

  // Stand-in ALU: ADD/SUB touch all flags, AND only Z, shift N/Z, HLT none, others XOR
  function automatic void alu_f(input logic [3:0] op, input logic [15:0] a, b, input logic [3:0] sh,
                                output logic [15:0] d, output logic o, z, n, cv, cz, cn);
    o = 1'b0; cv = 1'b1; cz = 1'b1; cn = 1'b1;
    case (op)
      4'h0: begin d = a + b; o = (a[15] == b[15]) && (d[15] != a[15]); end
      4'h1: begin d = a - b; o = (a[15] != b[15]) && (d[15] != a[15]); end
      4'h2: begin d = a & b; cv = 1'b0; cn = 1'b0; end
      4'h4: begin d = a << sh; cv = 1'b0; end
      4'hF: begin d = '0; cv = 1'b0; cz = 1'b0; cn = 1'b0; end
      default: d = a ^ b;
    endcase
    z = (d == 16'h0);
    n = d[15];
  endfunction

  always_comb alu_f(alu_op, alu_src0, alu_src1, alu_shamt, alu_dst, alu_ov, alu_zr, alu_neg,
                    alu_change_v, alu_change_z, alu_change_n);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int id, input logic [3:0] op, input logic [15:0] a, b, input logic [3:0] sh);
    exp_t e;
    logic [15:0] d;
    logic o, z, n, cv, cz, cn;
    alu_f(op, a, b, sh, d, o, z, n, cv, cz, cn);
    if (id == 0) begin
      if (cv) mv = o;
      if (cz) mz = z;
      if (cn) mn = n;
      if (op == 4'hF) mh = 1'b1;
    end
    e.id = id;
    e.e = (id == 1) && op[3];
    e.d = e.e ? 16'h0 : d;
    e.v = mv; e.z = mz; e.n = mn; e.h = mh;
    e.t = cyc;
    sb.push_back(e);
    glog.push_back(id);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      mv = 1'b0; mz = 1'b0; mn = 1'b0; mh = 1'b0; prev_v = 1'b0;
    end else begin
      chk("one_ready", {31'b0, req0_ready && req1_ready}, 0);
      if (req0_valid && req0_ready) push(0, req0_op, req0_src0, req0_src1, req0_shamt);
      if (req1_valid && req1_ready) push(1, req1_op, req1_src0, req1_src1, req1_shamt);
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = sb[0];
          chk("rsp_both", {31'b0, rsp0_valid && rsp1_valid}, 0);
          chk("rsp_id", {31'b0, rsp1_valid}, e.id);
          chk("rsp_data", {16'b0, rsp_data}, {16'b0, e.d});
          if (e.id == 1) chk("rsp1_err", {31'b0, rsp1_err}, {31'b0, e.e});
          chk("flag_v", {31'b0, flag_v}, {31'b0, e.v});
          chk("flag_z", {31'b0, flag_z}, {31'b0, e.z});
          chk("flag_n", {31'b0, flag_n}, {31'b0, e.n});
          chk("halted", {31'b0, halted}, {31'b0, e.h});
          if (!prev_v) chk("latency", cyc - e.t, 2);
          last_data = rsp_data;
          last_err = rsp1_err;
          if (e.id == 1 ? rsp1_ready : rsp0_ready) void'(sb.pop_front());
        end
      end
      prev_v = rsp0_valid || rsp1_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [3:0] op, input logic [15:0] a, b, input logic [3:0] sh);
    logic ok = 1'b0;
    if (id == 0) begin req0_op = op; req0_src0 = a; req0_src1 = b; req0_shamt = sh; req0_valid = 1'b1; end
    else begin req1_op = op; req1_src0 = a; req1_src1 = b; req1_shamt = sh; req1_valid = 1'b1; end
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      ok = (id == 0) ? req0_ready : req1_ready;
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("accept", {31'b0, ok}, 1);
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || rsp0_valid || rsp1_valid) && k < 50) begin
      step();
      k++;
    end
    chk("drain_timeout", {31'b0, k < 50}, 1);
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 0);
    chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 0);
    chk("rst_rsp_data", {16'b0, rsp_data}, 0);
    chk("rst_rsp1_err", {31'b0, rsp1_err}, 0);
    chk("rst_alu", {alu_op, alu_shamt, alu_src0 | alu_src1}, 0);
    chk("rst_flags", {28'b0, flag_v, flag_z, flag_n, halted}, 0);
    step();
    // tie on every IDLE cycle: first grant goes to requester 0, then alternates
    glog.delete();
    req0_op = 4'h0; req0_src0 = 16'h0001; req0_src1 = 16'h0001; req0_shamt = '0;
    req1_op = 4'h1; req1_src0 = 16'h0005; req1_src1 = 16'h0003; req1_shamt = '0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (14) step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
    chk("rr_count", {31'b0, glog.size() >= 4}, 1);
    if (glog.size() >= 4) for (int i = 0; i < 4; i++) chk("rr_order", glog[i], i % 2);
    send(0, 4'h0, 16'h7FFF, 16'h0001, 4'd0);
    drain();
    chk("add_data", {16'b0, last_data}, 32'h8000);
    chk("add_flags", {29'b0, flag_v, flag_z, flag_n}, 3'b101);
    send(0, 4'h2, 16'h00F0, 16'h0F00, 4'd0);
    drain();
    chk("and_flags", {29'b0, flag_v, flag_z, flag_n}, 3'b111);
    send(1, 4'hA, 16'h1234, 16'h00FF, 4'd0);
    drain();
    chk("ill_err", {31'b0, last_err}, 1);
    chk("ill_data", {16'b0, last_data}, 0);
    chk("ill_flags", {29'b0, flag_v, flag_z, flag_n}, 3'b111);
    send(1, 4'h1, 16'h0009, 16'h0004, 4'd0);
    drain();
    chk("sub1_err", {31'b0, last_err}, 0);
    chk("sub1_data", {16'b0, last_data}, 5);
    // response stalled by rsp0_ready=0 while requester 1 waits
    rsp0_ready = 1'b0;
    send(0, 4'h4, 16'h0003, 16'h0000, 4'd4);
    req1_op = 4'h1; req1_src0 = 16'h0007; req1_src1 = 16'h0002; req1_shamt = '0;
    req1_valid = 1'b1;
    step();
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, rsp0_valid}, 1);
      chk("stall_data", {16'b0, rsp_data}, 32'h0030);
      chk("stall_no_grant", {31'b0, req1_ready}, 0);
      step();
    end
    rsp0_ready = 1'b1;
    step();
    @(negedge clk);
    chk("stall_release", {31'b0, rsp0_valid}, 0);
    chk("stall_next_grant", {31'b0, req1_ready}, 1);
    step();
    req1_valid = 1'b0;
    drain();
    // HLT blocks further grants until reset
    send(0, 4'hF, 16'h0000, 16'h0000, 4'd0);
    drain();
    chk("hlt_set", {31'b0, halted}, 1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("hlt_no_ready", {30'b0, req0_ready, req1_ready}, 0);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("hlt_cleared", {31'b0, halted}, 0);
    step();
    send(0, 4'h0, 16'h4000, 16'h4000, 4'd0);
    drain();
    chk("pre_abort_flags", {29'b0, flag_v, flag_z, flag_n}, 3'b101);
    send(0, 4'h1, 16'h0001, 16'h0002, 4'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_flags", {28'b0, flag_v, flag_z, flag_n, halted}, 0);
    chk("abort_alu_op", {28'b0, alu_op}, 0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_rsp", {30'b0, rsp0_valid, rsp1_valid}, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
